// File: rtl/audio_stream_pkg.sv
// Shared register map, control bit positions and sample types for audio_sample_streamer.
// The optional low-watermark interrupt is enabled by defining AUDIO_STREAMER_IRQ_EN.
package audio_stream_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_MUTE_BIT   = 1;
  localparam int CTRL_LOW_WM_LSB = 16;
  localparam int CTRL_LOW_WM_W   = 10;

  localparam int STATUS_OVF_BIT = 31;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

  // Left occupies the upper half so a write word casts straight into a sample.
  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock FIFO with a registered first-word-fall-through read port.
// rdata always shows the head entry; a push into an empty FIFO is bypassed into it.
module audio_sample_fifo #(
  parameter int DEPTH = 256,
  parameter int W = 32,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic          push_ok;
  logic          pop_ok;

  assign full       = (level == LVL_W'(DEPTH));
  assign empty      = (level == '0);
  assign push_ok    = push & ~full;
  assign pop_ok     = pop & ~empty;
  assign rd_ptr_nxt = pop_ok ? rd_ptr + AW'(1) : rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Memory and read register stay unreset so they can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
    rdata <= (push_ok && (wr_ptr == rd_ptr_nxt)) ? wdata : mem[rd_ptr_nxt];
  end

endmodule

// File: rtl/audio_sample_streamer.sv
// Avalon-MM slave buffering packed stereo PCM words and streaming them as paired L/R samples.
// Define AUDIO_STREAMER_IRQ_EN to add the low-watermark interrupt and the low_wm control field.
module audio_sample_streamer
  import audio_stream_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int SAMPLE_W = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [1:0]          address,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [SAMPLE_W-1:0] left_data,
  output logic                left_valid,
  input  logic                left_ready,
  output logic [SAMPLE_W-1:0] right_data,
  output logic                right_valid,
  input  logic                right_ready
`ifdef AUDIO_STREAMER_IRQ_EN
  ,
  output logic                irq
`endif
);

  stereo_sample_t           fifo_wdata;
  stereo_sample_t           fifo_rdata;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [LVL_W-1:0]         level;
  logic                     enable;
  logic                     mute;
  logic [CTRL_LOW_WM_W-1:0] low_wm;
  logic                     overflow;
  logic [15:0]              underrun_cnt;
  logic                     data_wr;
  logic                     status_wr;
  logic                     ctrl_wr;
  logic                     l_take;
  logic                     r_take;
  logic                     load;
  logic                     underrun_hit;

  assign data_wr   = chipselect & write & (address == ADDR_DATA);
  assign status_wr = chipselect & write & (address == ADDR_STATUS);
  assign ctrl_wr   = chipselect & write & (address == ADDR_CTRL);

  assign fifo_wdata = stereo_sample_t'(writedata);
  assign fifo_push  = data_wr;
  assign fifo_pop   = load;

  audio_sample_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(stereo_sample_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Each channel transfers on a cycle with valid & ready; valid and data hold until then.
  // A new pair only loads once both channels are free, keeping L and R paired.
  assign l_take       = left_valid & left_ready;
  assign r_take       = right_valid & right_ready;
  assign load         = enable & (~left_valid | l_take) & (~right_valid | r_take) & ~fifo_empty;
  assign underrun_hit = enable & fifo_empty & ~left_valid & ~right_valid & left_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      left_valid  <= 1'b0;
      right_valid <= 1'b0;
      left_data   <= '0;
      right_data  <= '0;
    end else if (load) begin
      left_valid  <= 1'b1;
      right_valid <= 1'b1;
      left_data   <= mute ? '0 : SAMPLE_W'(fifo_rdata.left);
      right_data  <= mute ? '0 : SAMPLE_W'(fifo_rdata.right);
    end else begin
      if (l_take) left_valid  <= 1'b0;
      if (r_take) right_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable <= 1'b0;
      mute   <= 1'b0;
    end else if (ctrl_wr) begin
      enable <= writedata[CTRL_ENABLE_BIT];
      mute   <= writedata[CTRL_MUTE_BIT];
    end
  end

  // A dropped push in the same cycle as a clear still leaves overflow set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (status_wr) overflow <= 1'b0;
      if (fifo_push && fifo_full) overflow <= 1'b1;
      if (status_wr) underrun_cnt <= '0;
      else if (underrun_hit && (underrun_cnt != UNDERRUN_MAX)) underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

`ifdef AUDIO_STREAMER_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) low_wm <= '0;
    else if (ctrl_wr) low_wm <= writedata[CTRL_LOW_WM_LSB +: CTRL_LOW_WM_W];
  end

  // With low_wm = 0 the clear term always wins, so the interrupt never fires.
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else if (status_wr || (32'(level) >= 32'(low_wm))) irq <= 1'b0;
    else if (enable) irq <= 1'b1;
  end
`else
  assign low_wm = '0;
`endif

  always_comb begin
    readdata = '0;
    if (chipselect && read) begin
      case (address)
        ADDR_DATA:   readdata = 32'(level);
        ADDR_STATUS: readdata = {overflow, 15'b0, underrun_cnt};
        ADDR_CTRL: begin
          readdata[CTRL_ENABLE_BIT] = enable;
          readdata[CTRL_MUTE_BIT]   = mute;
          readdata[CTRL_LOW_WM_LSB +: CTRL_LOW_WM_W] = low_wm;
        end
        default: readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Scoreboarded bench for audio_sample_streamer: expected L/R samples are queued at push time
// and a negedge monitor compares them as each channel hands off.
module tb_audio_sample_streamer;
  import audio_stream_pkg::*;

  localparam int DEPTH = 256;
  localparam int SAMPLE_W = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                chipselect;
  logic                write;
  logic                read;
  logic [1:0]          address;
  logic [31:0]         writedata;
  logic [31:0]         readdata;
  logic [SAMPLE_W-1:0] left_data;
  logic                left_valid;
  logic                left_ready;
  logic [SAMPLE_W-1:0] right_data;
  logic                right_valid;
  logic                right_ready;
`ifdef AUDIO_STREAMER_IRQ_EN
  logic                irq;
`endif

  int total = 0;
  int bad = 0;
  logic [SAMPLE_W-1:0] exp_l_q[$];
  logic [SAMPLE_W-1:0] exp_r_q[$];
  logic rand_ready = 1'b0;

  audio_sample_streamer #(.DEPTH(DEPTH), .SAMPLE_W(SAMPLE_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .left_data   (left_data),
    .left_valid  (left_valid),
    .left_ready  (left_ready),
    .right_data  (right_data),
    .right_valid (right_valid),
    .right_ready (right_ready)
`ifdef AUDIO_STREAMER_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (left_valid && left_ready) begin
        if (exp_l_q.size() == 0) check("left_unexpected", 32'(left_data), 32'hDEAD_0000);
        else check("left_data", 32'(left_data), 32'(exp_l_q.pop_front()));
      end
      if (right_valid && right_ready) begin
        if (exp_r_q.size() == 0) check("right_unexpected", 32'(right_data), 32'hDEAD_0000);
        else check("right_data", 32'(right_data), 32'(exp_r_q.pop_front()));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) begin
      left_ready  = 1'($urandom_range(0, 1));
      right_ready = 1'($urandom_range(0, 1));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    #1;
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
    step();
  endtask

  task automatic push_exp(input logic [31:0] d, input bit muted);
    bus_write(ADDR_DATA, d);
    exp_l_q.push_back(muted ? 16'h0 : d[31:16]);
    exp_r_q.push_back(muted ? 16'h0 : d[15:0]);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_l_q.size() != 0 || exp_r_q.size() != 0 || left_valid || right_valid) && n < budget) begin
      step();
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] d;
    logic [31:0] words[3];
    int model_level;
    bit model_ovf;
    bit found;

    // reset with every input active
    reset = 1'b1; chipselect = 1'b1; write = 1'b1; read = 1'b1; address = ADDR_DATA;
    writedata = $urandom; left_ready = 1'b1; right_ready = 1'b1;
    repeat (3) step();
    check("rst_left_valid", 32'(left_valid), 32'd0);
    check("rst_right_valid", 32'(right_valid), 32'd0);
    check("rst_left_data", 32'(left_data), 32'd0);
    check("rst_right_data", 32'(right_data), 32'd0);
    check("rst_readdata", readdata, 32'd0);
`ifdef AUDIO_STREAMER_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif
    chipselect = 1'b0; write = 1'b0; read = 1'b0; reset = 1'b0;
    step();
    bus_read(ADDR_DATA, rd);   check("rst_level", rd, 32'd0);
    bus_read(ADDR_STATUS, rd); check("rst_status", rd, 32'd0);
    bus_read(ADDR_CTRL, rd);   check("rst_ctrl", rd, 32'd0);

    // in-order streaming and two-cycle latency
    bus_write(ADDR_CTRL, 32'h1);
    words[0] = 32'h1111_AAAA; words[1] = 32'h2222_BBBB; words[2] = 32'h3333_CCCC;
    push_exp(words[0], 0);
    check("lat_cycle1_idle", 32'(left_valid), 32'd0);
    push_exp(words[1], 0);
    check("lat_cycle2_left", 32'(left_valid), 32'd1);
    check("lat_cycle2_right", 32'(right_valid), 32'd1);
    push_exp(words[2], 0);
    wait_drain(50);

    // skewed ready keeps the pair together
    left_ready = 1'b0; right_ready = 1'b0;
    push_exp($urandom, 0);
    push_exp($urandom, 0);
    for (int n = 0; n < 10 && !left_valid; n++) step();
    check("skew_first_valid", 32'(left_valid), 32'd1);
    left_ready = 1'b1;
    step();
    left_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check("skew_left_idle", 32'(left_valid), 32'd0);
      check("skew_right_held", 32'(right_valid), 32'd1);
      if (k == 3) right_ready = 1'b1;
      step();
    end
    right_ready = 1'b0;
    check("skew_reload_left", 32'(left_valid), 32'd1);
    check("skew_reload_right", 32'(right_valid), 32'd1);
    left_ready = 1'b1; right_ready = 1'b1;
    wait_drain(50);

    // fill while disabled, overflow, then drain with random readies
    bus_write(ADDR_CTRL, 32'h0);
    bus_write(ADDR_STATUS, 32'h0);
    model_level = 0; model_ovf = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      d = $urandom;
      if (model_level < DEPTH) begin
        push_exp(d, 0);
        model_level++;
      end else begin
        bus_write(ADDR_DATA, d);
        model_ovf = 1;
      end
    end
    bus_read(ADDR_DATA, rd);   check("full_level", rd, 32'(model_level));
    bus_read(ADDR_STATUS, rd); check("full_overflow", 32'(rd[31]), 32'(model_ovf));
    bus_write(ADDR_CTRL, 32'h1);
    rand_ready = 1'b1;
    wait_drain(20000);
    rand_ready = 1'b0;
    step();
    left_ready = 1'b1; right_ready = 1'b1;
    bus_read(ADDR_DATA, rd);   check("drained_level", rd, 32'd0);

    // underrun counting and clear
    left_ready = 1'b0; right_ready = 1'b0;
    bus_write(ADDR_STATUS, 32'h0);
    left_ready = 1'b1;
    repeat (10) step();
    left_ready = 1'b0;
    bus_read(ADDR_STATUS, rd); check("underrun_ten", rd, 32'd10);
    bus_write(ADDR_STATUS, $urandom);
    bus_read(ADDR_STATUS, rd); check("underrun_clear", rd, 32'd0);

    // mute outputs zero pairs but still pops
    left_ready = 1'b1; right_ready = 1'b1;
    bus_write(ADDR_CTRL, 32'h2);
    for (int i = 0; i < 4; i++) push_exp($urandom, 1);
    bus_write(ADDR_CTRL, 32'h3);
    wait_drain(50);
    bus_read(ADDR_DATA, rd);   check("mute_level", rd, 32'd0);

    // low_wm field readback
    bus_write(ADDR_CTRL, 32'h0155_0001);
    bus_read(ADDR_CTRL, rd);
`ifdef AUDIO_STREAMER_IRQ_EN
    check("ctrl_readback", rd, 32'h0155_0001);
`else
    check("ctrl_readback", rd, 32'h0000_0001);
`endif
    bus_write(ADDR_CTRL, 32'h1);

    // randomized streaming
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_exp($urandom, 0);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_drain(5000);
    rand_ready = 1'b0;
    step();
    left_ready = 1'b1; right_ready = 1'b1;

`ifdef AUDIO_STREAMER_IRQ_EN
    // watermark crossing
    bus_write(ADDR_CTRL, 32'h0);
    for (int i = 0; i < 5; i++) push_exp($urandom, 0);
    bus_write(ADDR_CTRL, 32'h0004_0001);
    chipselect = 1'b1; read = 1'b1; address = ADDR_DATA;
    #1;
    found = 0;
    for (int n = 0; n < 30 && !found; n++) begin
      if (readdata == 32'd3) begin
        found = 1;
        check("irq_at_level3", 32'(irq), 32'd0);
        step();
        check("irq_rise", 32'(irq), 32'd1);
      end else begin
        step();
      end
    end
    check("irq_level3_seen", 32'(found), 32'd1);
    chipselect = 1'b0; read = 1'b0;
    wait_drain(50);
    bus_write(ADDR_CTRL, 32'h1);
    step();
    check("irq_cleared", 32'(irq), 32'd0);
`endif

    // reset mid-transfer discards everything
    left_ready = 1'b0; right_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(ADDR_DATA, $urandom);
    repeat (2) step();
    check("mid_valid_before", 32'(left_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_left_dropped", 32'(left_valid), 32'd0);
    check("mid_right_dropped", 32'(right_valid), 32'd0);
    bus_read(ADDR_DATA, rd);   check("mid_level", rd, 32'd0);

    // final report
    check("exp_left_empty", 32'(exp_l_q.size()), 32'd0);
    check("exp_right_empty", 32'(exp_r_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
